hex_stream_formatter: RTL and testbench

- Parametrised successor to the single-byte PS/2-to-UART hex monitor.
- Accepts words of DATA_BYTES bytes through a valid/ready port and buffers them in a small FIFO.
- Emits each word as ASCII hex (MS nibble first) to the UART transmit port, with separator, line-break and back-pressure handling.
- Sits between any byte/word source (ps2_rxtx, mouse packet assembler) and the uart block.

---
 rtl/hex_stream_formatter_pkg.sv | 32 +++
 rtl/hex_stream_formatter_if.sv | 14 +
 rtl/hex_stream_formatter_fifo.sv | 59 +++++
 rtl/hex_stream_formatter.sv | 116 +++++++++++
 tb/tb_hex_stream_formatter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/hex_stream_formatter_pkg.sv
// Shared types, ASCII constants and the nibble-to-ASCII mapping for the hex formatter.
// HEXFMT_LOWERCASE_EN selects lowercase a-f digits; the default build prints A-F.
package hexfmt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DIGIT = 3'd2,
      ST_SEP   = 3'd3,
      ST_CR    = 3'd4,
      ST_LF    = 3'd5
   } state_e;

   localparam logic [7:0] CHAR_SP      = 8'h20;
   localparam logic [7:0] CHAR_CR      = 8'h0D;
   localparam logic [7:0] CHAR_LF      = 8'h0A;
   localparam logic [7:0] CHAR_0       = 8'h30;
   localparam logic [7:0] CHAR_A_UPPER = 8'h41;
   localparam logic [7:0] CHAR_A_LOWER = 8'h61;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] a_base;
`ifdef HEXFMT_LOWERCASE_EN
      a_base = CHAR_A_LOWER;
`else
      a_base = CHAR_A_UPPER;
`endif
      if (nib < 4'd10) return CHAR_0 + {4'h0, nib};
      else             return a_base + {4'h0, nib - 4'd10};
   endfunction

endpackage

// File: rtl/hex_stream_formatter_if.sv
// Word-in / character-out bus of the hex formatter: valid/ready input plus UART TX write port.
interface hexfmt_if #(parameter int DATA_BYTES = 1);
   logic                      in_valid;
   logic [8*DATA_BYTES-1:0]   in_data;
   logic                      in_ready;
   logic                      tx_full;
   logic                      wr_uart;
   logic [7:0]                w_data;

   modport slave  (input  in_valid, in_data, tx_full,
                   output in_ready, wr_uart, w_data);
   modport master (output in_valid, in_data, tx_full,
                   input  in_ready, wr_uart, w_data);
endinterface

// File: rtl/hex_stream_formatter_fifo.sv
// Synchronous word FIFO; DEPTH must be a power of two so the pointers wrap for free.
module hexfmt_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/hex_stream_formatter.sv
// Buffers DATA_BYTES-wide words and prints each as ASCII hex, MS nibble first, with
// separator / CR LF line breaks and UART back-pressure. Build option: HEXFMT_LOWERCASE_EN.
module hex_stream_formatter
   import hexfmt_pkg::*;
#(
   parameter int         DATA_BYTES     = 1,
   parameter int         FIFO_DEPTH     = 4,
   parameter int         WORDS_PER_LINE = 8,
   parameter logic [7:0] SEP_CHAR       = 8'h20
) (
   input  logic      clk,
   input  logic      reset_n,
   hexfmt_if.slave   bus,
   output logic      overrun,
   output logic      busy
);
   localparam int W    = 8 * DATA_BYTES;
   localparam int NDIG = 2 * DATA_BYTES;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int LCW  = $clog2(WORDS_PER_LINE + 1);

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [LCW-1:0]   lc_q, lc_d;
   logic [W-1:0]     word_q, word_d;
   logic             wr_q, wr_d;
   logic [7:0]       wd_q, wd_d;
   logic             ovr_q, ovr_d;

   logic             fifo_full, fifo_empty, fifo_pop;
   logic [W-1:0]     fifo_dout;

   hexfmt_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (bus.in_valid && bus.in_ready),
      .pop     (fifo_pop),
      .din     (bus.in_data),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // in_ready depends only on registered FIFO occupancy, never on in_valid.
   assign bus.in_ready = !fifo_full;
   assign bus.wr_uart  = wr_q;
   assign bus.w_data   = wd_q;
   assign overrun      = ovr_q;
   assign busy         = !fifo_empty || (state_q != ST_IDLE);
   assign fifo_pop     = (state_q == ST_LOAD);
   assign ovr_d        = ovr_q || (bus.in_valid && fifo_full);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lc_d    = lc_q;
      word_d  = word_q;
      wr_d    = 1'b0;
      wd_d    = wd_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
         ST_LOAD: begin
            word_d  = fifo_dout;
            idx_d   = IW'(NDIG - 1);
            state_d = ST_DIGIT;
         end
         ST_DIGIT: if (!bus.tx_full) begin
            wr_d = 1'b1;
            wd_d = nibble_to_ascii(word_q[4*idx_q +: 4]);
            if (idx_q == '0)
               state_d = (lc_q == LCW'(WORDS_PER_LINE - 1)) ? ST_CR : ST_SEP;
            else
               idx_d = idx_q - 1'b1;
         end
         ST_SEP: if (!bus.tx_full) begin
            wr_d    = 1'b1;
            wd_d    = SEP_CHAR;
            lc_d    = lc_q + 1'b1;
            state_d = ST_IDLE;
         end
         ST_CR: if (!bus.tx_full) begin
            wr_d    = 1'b1;
            wd_d    = CHAR_CR;
            state_d = ST_LF;
         end
         ST_LF: if (!bus.tx_full) begin
            wr_d    = 1'b1;
            wd_d    = CHAR_LF;
            lc_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         lc_q    <= '0;
         word_q  <= '0;
         wr_q    <= 1'b0;
         wd_q    <= CHAR_SP;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lc_q    <= lc_d;
         word_q  <= word_d;
         wr_q    <= wr_d;
         wd_q    <= wd_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_hex_stream_formatter.sv
// Directed bench: two formatter instances (1-byte words / 2 per line, 2-byte words / 8 per line).
module tb_hex_stream_formatter;
   typedef logic [7:0] bq_t[$];

`ifdef HEXFMT_LOWERCASE_EN
   localparam logic [7:0] LA = 8'h61;
`else
   localparam logic [7:0] LA = 8'h41;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;
   logic ovrA, busyA, ovrB, busyB;
   bq_t  qA, qB;

   hexfmt_if #(.DATA_BYTES(1)) ifA();
   hexfmt_if #(.DATA_BYTES(2)) ifB();

   hex_stream_formatter #(.DATA_BYTES(1), .FIFO_DEPTH(4), .WORDS_PER_LINE(2), .SEP_CHAR(8'h20)) dutA (
      .clk(clk), .reset_n(reset_n), .bus(ifA), .overrun(ovrA), .busy(busyA));
   hex_stream_formatter #(.DATA_BYTES(2), .FIFO_DEPTH(4), .WORDS_PER_LINE(8), .SEP_CHAR(8'h20)) dutB (
      .clk(clk), .reset_n(reset_n), .bus(ifB), .overrun(ovrB), .busy(busyB));

   always #5 clk = ~clk;

   // Character capture for both UART ports.
   always @(negedge clk) begin
      if (ifA.wr_uart) qA.push_back(ifA.w_data);
      if (ifB.wr_uart) qB.push_back(ifB.w_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] d);
      @(negedge clk);
      ifA.in_valid = 1'b1;
      ifA.in_data  = d;
      @(posedge clk);
      #1 ifA.in_valid = 1'b0;
   endtask

   task automatic push_b(input logic [15:0] d);
      @(negedge clk);
      ifB.in_valid = 1'b1;
      ifB.in_data  = d;
      @(posedge clk);
      #1 ifB.in_valid = 1'b0;
   endtask

   // exp holds n characters right-aligned, first character most significant.
   task automatic expect_seq(input string tag, input int which, input int n, input logic [255:0] exp);
      int  cyc;
      bq_t got;
      cyc = 0;
      while (((which == 0) ? qA.size() : qB.size()) < n && cyc < 400) begin
         @(posedge clk);
         cyc++;
      end
      repeat (6) @(posedge clk);
      got = (which == 0) ? qA : qB;
      chk({tag, "/len"}, got.size(), n);
      for (int i = 0; i < n; i++)
         if (i < got.size()) chk(tag, {24'h0, got[i]}, {24'h0, exp[8*(n-1-i) +: 8]});
      if (which == 0) qA.delete(); else qB.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cyc, bad, acc;
      ifA.in_valid = 1'b0; ifA.in_data = '0; ifA.tx_full = 1'b0;
      ifB.in_valid = 1'b0; ifB.in_data = '0; ifB.tx_full = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", ifA.in_ready, 1);
      chk("rst_wr_uart",  ifA.wr_uart, 0);
      chk("rst_w_data",   ifA.w_data, 8'h20);
      chk("rst_overrun",  ovrA, 0);
      chk("rst_busy",     busyA, 0);
      @(negedge clk) reset_n = 1'b1;

      // 8'h3A: latency of 3 edges, then "3A "
      push_a(8'h3A);
      @(posedge clk); #1 chk("lat_e1", ifA.wr_uart, 0);
      @(posedge clk); #1 chk("lat_e2", ifA.wr_uart, 0);
      @(posedge clk); #1 chk("lat_e3", ifA.wr_uart, 1);
      chk("lat_char", ifA.w_data, 8'h33);
      cyc = 0;
      while (!(ifA.wr_uart && ifA.w_data == 8'h20) && cyc < 50) begin
         @(posedge clk); #1 cyc++;
      end
      chk("sp_seen", cyc < 50, 1);
      chk("busy_after_sp", busyA, 0);
      expect_seq("w3A", 0, 3, {8'h33, LA, 8'h20});

      // 8'hC5 with tx_full held after the first digit; line ends here
      push_a(8'hC5);
      cyc = 0;
      while (!ifA.wr_uart && cyc < 20) begin
         @(posedge clk); #1 cyc++;
      end
      chk("c5_first", ifA.w_data, LA + 8'd2);
      ifA.tx_full = 1'b1;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ifA.wr_uart) bad++;
      end
      chk("hold_no_write", bad, 0);
      ifA.tx_full = 1'b0;
      expect_seq("wC5", 0, 4, {LA + 8'd2, 8'h35, 8'h0D, 8'h0A});

      // Line wrap at 2 words per line
      push_a(8'h01); push_a(8'h02); push_a(8'h03);
      expect_seq("wrap", 0, 10, {8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h0D, 8'h0A,
                                 8'h30, 8'h33, 8'h20});

      // Overrun: 6 back-to-back words while UART is full
      ifA.tx_full = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ifA.in_valid = 1'b1;
         ifA.in_data  = 8'h10 + 8'(i);
         if (ifA.in_ready) acc++;
      end
      @(negedge clk) ifA.in_valid = 1'b0;
      chk("ovr_accepts", acc, 5);
      chk("ovr_flag", ovrA, 1);
      chk("ovr_in_ready", ifA.in_ready, 0);
      ifA.tx_full = 1'b0;
      expect_seq("ovr_out", 0, 18, {8'h31, 8'h30, 8'h0D, 8'h0A,
                                    8'h31, 8'h31, 8'h20,
                                    8'h31, 8'h32, 8'h0D, 8'h0A,
                                    8'h31, 8'h33, 8'h20,
                                    8'h31, 8'h34, 8'h0D, 8'h0A});

      // Reset mid-DIGIT with line count at 1 and a word waiting in the FIFO
      push_a(8'h20);
      expect_seq("w20", 0, 3, {8'h32, 8'h30, 8'h20});
      push_a(8'h7E); push_a(8'h7F);
      cyc = 0;
      while (!ifA.wr_uart && cyc < 20) begin
         @(posedge clk); #1 cyc++;
      end
      chk("pre_rst_write", ifA.wr_uart, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_wr_uart",  ifA.wr_uart, 0);
      chk("arst_in_ready", ifA.in_ready, 1);
      chk("arst_overrun",  ovrA, 0);
      chk("arst_busy",     busyA, 0);
      @(negedge clk) reset_n = 1'b1;
      qA.delete();
      qB.delete();
      push_a(8'h5A); push_a(8'h6B);
      expect_seq("post_rst", 0, 7, {8'h35, LA, 8'h20, 8'h36, LA + 8'd1, 8'h0D, 8'h0A});

      // Two-byte word
      push_b(16'hBEEF);
      expect_seq("wBEEF", 1, 5, {LA + 8'd1, LA + 8'd4, LA + 8'd4, LA + 8'd5, 8'h20});
      chk("b_busy_end", busyB, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
